dmem_responder: RTL and testbench

Data-memory responder (slave) on the pipeline's load/store bus. It is the target end of the accesses issued by the memory stage: it accepts one request at a time, holds off new requests with stall while busy, and completes each transfer with a single-cycle ack. Latency is configurable so the pipeline stall path can be exercised against slow memory. Storage is an internal word array with byte-lane write enables.

---
 rtl/dmem_responder_pkg.sv | 23 ++
 rtl/dmem_responder_if.sv | 39 +++
 rtl/dmem_responder_bank.sv | 44 ++++
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        DR_IDLE = 2'd0,
        DR_WAIT = 2'd1,
        DR_RESP = 2'd2
    } dr_state_e;

    localparam int unsigned DR_CNT_W = 4;
    localparam int unsigned DR_LANES = 4;

    // Expand a byte-lane select into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [DR_LANES-1:0] sel);
        logic [31:0] m;
        m = '0;
        for (int unsigned l = 0; l < DR_LANES; l++) begin
            m[8*l +: 8] = {8{sel[l]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store bus between the memory stage (master) and the responder (slave).
// DMEM_ERR_EN adds the dr_o_err range-error response.
interface dmem_responder_if
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned AWIDTH_MEM = 32
) ();

    logic                  dr_i_cyc;
    logic                  dr_i_stb;
    logic                  dr_i_we;
    logic [AWIDTH_MEM-1:0] dr_i_addr;
    logic [DWIDTH-1:0]     dr_i_data;
    logic [DR_LANES-1:0]   dr_i_sel;
    logic                  dr_o_ack;
    logic                  dr_o_stall;
    logic [DWIDTH-1:0]     dr_o_data;
`ifdef DMEM_ERR_EN
    logic                  dr_o_err;
`endif

    modport master (
        output dr_i_cyc, dr_i_stb, dr_i_we, dr_i_addr, dr_i_data, dr_i_sel,
`ifdef DMEM_ERR_EN
        input  dr_o_err,
`endif
        input  dr_o_ack, dr_o_stall, dr_o_data
    );

    modport slave (
        input  dr_i_cyc, dr_i_stb, dr_i_we, dr_i_addr, dr_i_data, dr_i_sel,
`ifdef DMEM_ERR_EN
        output dr_o_err,
`endif
        output dr_o_ack, dr_o_stall, dr_o_data
    );

endinterface

// File: rtl/dmem_responder_bank.sv
// Single-port word array with 4-lane write mask and registered, lane-masked read.
module dmem_bank
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned DEPTH  = 1024,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [DWIDTH-1:0]   wdata_i,
    input  logic [DR_LANES-1:0] sel_i,
    output logic [DWIDTH-1:0]   rdata_o
);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rdata_q;

    // Lane-masked write; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && en_i && we_i) begin
            for (int unsigned l = 0; l < DR_LANES; l++) begin
                if (sel_i[l]) mem_q[idx_i][8*l +: 8] <= wdata_i[8*l +: 8];
            end
        end
    end

    // Read data is held only for the cycle after a load access, else zero.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[idx_i] & lane_mask(sel_i);
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, configurable wait states,
// single-cycle ack. DMEM_ERR_EN enables the out-of-range error response.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned AWIDTH_MEM = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LATENCY    = 1
) (
    input  logic             dr_clk,
    input  logic             dr_rst,
    dmem_responder_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [DR_CNT_W-1:0] CNT_LOAD = DR_CNT_W'(LATENCY == 0 ? 0 : LATENCY - 1);

    dr_state_e            state_q;
    logic [DR_CNT_W-1:0]  cnt_q;
    logic                 ack_q;
    logic                 stall_q;
    logic                 err_q;
    logic                 we_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DWIDTH-1:0]    data_q;
    logic [DR_LANES-1:0]  sel_q;
    logic                 oor_q;

    logic                 accept_d;
    logic                 enter_resp_d;
    logic                 we_d;
    logic [IDX_W-1:0]     idx_d;
    logic [DWIDTH-1:0]    data_d;
    logic [DR_LANES-1:0]  sel_d;
    logic                 bus_oor_d;
    logic                 oor_d;
    logic                 bank_en_d;
    logic                 unused_addr_bits;

`ifdef DMEM_ERR_EN
    assign bus_oor_d        = |bus.dr_i_addr[AWIDTH_MEM-1:IDX_W+2];
    assign unused_addr_bits = ^bus.dr_i_addr[1:0];
`else
    assign bus_oor_d        = 1'b0;
    assign unused_addr_bits = ^{bus.dr_i_addr[AWIDTH_MEM-1:IDX_W+2], bus.dr_i_addr[1:0]};
`endif

    // Bank access happens on the edge entering RESP; with zero latency that is the
    // accept edge itself, so the bus fields feed the bank directly from IDLE.
    always_comb begin
        accept_d     = (state_q == DR_IDLE) && bus.dr_i_cyc && bus.dr_i_stb && !stall_q;
        enter_resp_d = (accept_d && (LATENCY == 0)) ||
                       ((state_q == DR_WAIT) && (cnt_q == '0) && bus.dr_i_cyc);
        if (state_q == DR_IDLE) begin
            we_d   = bus.dr_i_we;
            idx_d  = bus.dr_i_addr[IDX_W+1:2];
            data_d = bus.dr_i_data;
            sel_d  = bus.dr_i_sel;
            oor_d  = bus_oor_d;
        end else begin
            we_d   = we_q;
            idx_d  = idx_q;
            data_d = data_q;
            sel_d  = sel_q;
            oor_d  = oor_q;
        end
        bank_en_d = enter_resp_d && dr_rst && !oor_d;
    end

    // Request FSM with registered ack/stall/err and holding registers.
    always_ff @(posedge dr_clk) begin
        if (!dr_rst) begin
            state_q <= DR_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            oor_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                DR_IDLE: begin
                    if (accept_d) begin
                        we_q    <= bus.dr_i_we;
                        idx_q   <= bus.dr_i_addr[IDX_W+1:2];
                        data_q  <= bus.dr_i_data;
                        sel_q   <= bus.dr_i_sel;
                        oor_q   <= bus_oor_d;
                        stall_q <= 1'b1;
                        if (LATENCY == 0) begin
                            state_q <= DR_RESP;
                            ack_q   <= !bus_oor_d;
                            err_q   <= bus_oor_d;
                        end else begin
                            state_q <= DR_WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                DR_WAIT: begin
                    if (!bus.dr_i_cyc) begin
                        state_q <= DR_IDLE;
                        stall_q <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= DR_RESP;
                        ack_q   <= !oor_q;
                        err_q   <= oor_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DR_RESP: begin
                    state_q <= DR_IDLE;
                    stall_q <= 1'b0;
                end
                default: begin
                    state_q <= DR_IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    dmem_bank #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk_i   (dr_clk),
        .rst_ni  (dr_rst),
        .en_i    (bank_en_d),
        .we_i    (we_d),
        .idx_i   (idx_d),
        .wdata_i (data_d),
        .sel_i   (sel_d),
        .rdata_o (bus.dr_o_data)
    );

    assign bus.dr_o_ack   = ack_q;
    assign bus.dr_o_stall = stall_q;
`ifdef DMEM_ERR_EN
    assign bus.dr_o_err   = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 2, 3 and 0
// share stimulus, each gated by its own dr_i_cyc. Honours DMEM_ERR_EN.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;

    logic [2:0]  ack_v;
    logic [2:0]  stall_v;
    logic [2:0]  err_v;
    logic [31:0] rdata_v [3];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder_if #(.DWIDTH(32), .AWIDTH_MEM(32)) bus ();

        assign bus.dr_i_cyc  = cyc[g];
        assign bus.dr_i_stb  = stb;
        assign bus.dr_i_we   = we;
        assign bus.dr_i_addr = addr;
        assign bus.dr_i_data = wdata;
        assign bus.dr_i_sel  = sel;
        assign ack_v[g]      = bus.dr_o_ack;
        assign stall_v[g]    = bus.dr_o_stall;
        assign rdata_v[g]    = bus.dr_o_data;
`ifdef DMEM_ERR_EN
        assign err_v[g]      = bus.dr_o_err;
`else
        assign err_v[g]      = 1'b0;
`endif

        dmem_responder #(
            .DWIDTH     (32),
            .AWIDTH_MEM (32),
            .DEPTH      (1024),
            .LATENCY    (g == 0 ? 2 : (g == 1 ? 3 : 0))
        ) u_dut (
            .dr_clk (clk),
            .dr_rst (rst_n),
            .bus    (bus)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transfer on instance d; returns data, cycles from accept to
    // response, whether stall stayed high throughout, and the ack/err flags seen.
    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] dat, input logic [3:0] s,
                        output logic [31:0] rd, output int ncyc,
                        output logic stall_ok, output logic ak, output logic er);
        logic done;
        @(negedge clk);
        cyc[d] = 1'b1; stb = 1'b1; we = w; addr = a; wdata = dat; sel = s;
        @(posedge clk);
        #1 stb = 1'b0;
        ncyc = 0; stall_ok = 1'b1; rd = '0; ak = 1'b0; er = 1'b0; done = 1'b0;
        while (!done && ncyc < 20) begin
            @(negedge clk);
            ncyc++;
            if (!stall_v[d]) stall_ok = 1'b0;
            if (ack_v[d] || err_v[d]) begin
                done = 1'b1;
                rd = rdata_v[d];
                ak = ack_v[d];
                er = err_v[d];
            end
        end
        cyc[d] = 1'b0;
        check("xfer_done", {31'b0, done}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int          nc;
        logic        sok, ak, er;
        int          acks, stalls;

        cyc = '0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack",   {29'b0, ack_v},   32'd0);
        check("rst_stall", {29'b0, stall_v}, 32'd0);
        check("rst_data",  rdata_v[0],       32'd0);
        rst_n = 1'b1;

        // LATENCY=2 store then load
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, nc, sok, ak, er);
        check("l2_store_lat", 32'(nc), 32'd3);
        check("l2_store_stall", {31'b0, sok}, 32'd1);
        @(negedge clk);
        check("l2_post_ack", {31'b0, ack_v[0]}, 32'd0);
        check("l2_post_stall", {31'b0, stall_v[0]}, 32'd0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, nc, sok, ak, er);
        check("l2_load_data", rd, 32'hDEADBEEF);
        check("l2_load_lat", 32'(nc), 32'd3);

        // byte-lane write and masked reads
        xfer(0, 1'b1, 32'h10, 32'h0000AB00, 4'b0010, rd, nc, sok, ak, er);
        xfer(0, 1'b0, 32'h13, 32'h0, 4'hF, rd, nc, sok, ak, er);
        check("lane_full", rd, 32'hDEADABEF);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'b0011, rd, nc, sok, ak, er);
        check("lane_low", rd, 32'h0000ABEF);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'b0000, rd, nc, sok, ak, er);
        check("lane_none_ack", {31'b0, ak}, 32'd1);
        check("lane_none", rd, 32'h0);

        // LATENCY=3 abort in second WAIT cycle
        xfer(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, nc, sok, ak, er);
        check("l3_lat", 32'(nc), 32'd4);
        @(negedge clk);
        cyc[1] = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; sel = 4'hF;
        @(posedge clk);
        #1 stb = 1'b0;
        acks = 0;
        @(negedge clk);
        acks += int'(ack_v[1]);
        @(negedge clk);
        acks += int'(ack_v[1]);
        cyc[1] = 1'b0;
        @(negedge clk);
        check("abort_stall", {31'b0, stall_v[1]}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            acks += int'(ack_v[1]);
            @(negedge clk);
        end
        check("abort_acks", 32'(acks), 32'd0);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, rd, nc, sok, ak, er);
        check("abort_nowrite", rd, 32'hCAFEF00D);

        // continuous strobe on LATENCY=2: one ack per 4 cycles
        @(negedge clk);
        cyc[0] = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'hF;
        acks = 0; stalls = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            acks   += int'(ack_v[0]);
            stalls += int'(stall_v[0]);
        end
        cyc[0] = 1'b0; stb = 1'b0;
        check("stb_acks", 32'(acks), 32'd3);
        check("stb_stalls", 32'(stalls), 32'd9);
        repeat (2) @(negedge clk);

        // reset while in WAIT
        xfer(0, 1'b1, 32'h30, 32'h0A0B0C0D, 4'hF, rd, nc, sok, ak, er);
        @(negedge clk);
        cyc[0] = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'hFFFFFFFF; sel = 4'hF;
        @(posedge clk);
        #1 stb = 1'b0;
        @(negedge clk);
        check("wait_stall", {31'b0, stall_v[0]}, 32'd1);
        rst_n = 1'b0; cyc[0] = 1'b0;
        @(negedge clk);
        check("wrst_ack",   {31'b0, ack_v[0]},   32'd0);
        check("wrst_stall", {31'b0, stall_v[0]}, 32'd0);
        check("wrst_data",  rdata_v[0],          32'd0);
        rst_n = 1'b1;
        xfer(0, 1'b0, 32'h30, 32'h0, 4'hF, rd, nc, sok, ak, er);
        check("wrst_nowrite", rd, 32'h0A0B0C0D);

        // LATENCY=0
        xfer(2, 1'b1, 32'h40, 32'h55AA55AA, 4'hF, rd, nc, sok, ak, er);
        check("l0_store_lat", 32'(nc), 32'd1);
        xfer(2, 1'b0, 32'h40, 32'h0, 4'hF, rd, nc, sok, ak, er);
        check("l0_load_lat", 32'(nc), 32'd1);
        check("l0_load_data", rd, 32'h55AA55AA);

        // out-of-range address
`ifdef DMEM_ERR_EN
        xfer(0, 1'b0, 32'h1000, 32'h0, 4'hF, rd, nc, sok, ak, er);
        check("oor_err", {31'b0, er}, 32'd1);
        check("oor_ack", {31'b0, ak}, 32'd0);
        check("oor_data", rd, 32'h0);
        check("oor_lat", 32'(nc), 32'd3);
`else
        xfer(0, 1'b1, 32'h1000, 32'h13572468, 4'hF, rd, nc, sok, ak, er);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, nc, sok, ak, er);
        check("alias_data", rd, 32'h13572468);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
